// File: rtl/note_sprite_drawer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : note_sprite_drawer                                           |
// | Description : Per-lane sprite pass. Each frame tick erases the note at its |
// |               previous row, then draws it at the new row, emitting one VGA |
// |               pixel write per cycle. Optional macro SKIP_UNCHANGED_EN skips|
// |               the pass when the row has not changed.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module note_sprite_drawer #(
    parameter int          LANE_X   = 20,
    parameter int          SPR_W    = 4,
    parameter int          SPR_H    = 4,
    parameter int          SCREEN_H = 120,
    parameter logic [2:0]  NOTE_COL = 3'b110,
    parameter logic [2:0]  BG_COL   = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] new_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    localparam logic [3:0] c_COL_LAST = 4'(SPR_W - 1);
    localparam logic [3:0] c_ROW_LAST = 4'(SPR_H - 1);
    localparam logic [7:0] c_LANE_X   = 8'(LANE_X);
    localparam logic [8:0] c_SCREEN_H = 9'(SCREEN_H);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_col;
    logic [3:0] r_row;
    logic [3:0] w_col_nx;
    logic [3:0] w_row_nx;
    logic [7:0] r_cur_y;
    logic [7:0] r_old_y;
    logic       r_old_valid;

    logic [7:0] r_vga_x;
    logic [6:0] r_vga_y;
    logic [2:0] r_colour;
    logic       r_plot;
    logic       r_busy;
    logic       r_done;

    logic       w_skip;
    logic       w_pix_active;
    logic       w_last_col;
    logic       w_last_pix;
    logic [7:0] w_base_y;
    logic [8:0] w_sum;

`ifdef SKIP_UNCHANGED_EN
    assign w_skip = r_old_valid && (new_y == r_old_y);
`else
    assign w_skip = 1'b0;
`endif

    assign w_pix_active = (r_state == S_ERASE) || (r_state == S_DRAW);
    assign w_last_col   = (r_col == c_COL_LAST);
    assign w_last_pix   = w_last_col && (r_row == c_ROW_LAST);
    assign w_base_y     = (r_state == S_ERASE) ? r_old_y : r_cur_y;
    // Nine-bit sum so rows past the bottom edge are detected rather than wrapped.
    assign w_sum        = {1'b0, w_base_y} + {5'd0, r_row};

    always_comb begin
        w_next   = r_state;
        w_col_nx = r_col;
        w_row_nx = r_row;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_col_nx = 4'd0;
                    w_row_nx = 4'd0;
                    if (w_skip)
                        w_next = S_FIN;
                    else if (r_old_valid)
                        w_next = S_ERASE;
                    else
                        w_next = S_DRAW;
                end
            end
            S_ERASE, S_DRAW: begin
                if (w_last_pix) begin
                    w_col_nx = 4'd0;
                    w_row_nx = 4'd0;
                    w_next   = (r_state == S_ERASE) ? S_DRAW : S_FIN;
                end else if (w_last_col) begin
                    w_col_nx = 4'd0;
                    w_row_nx = r_row + 4'd1;
                end else begin
                    w_col_nx = r_col + 4'd1;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_col       <= 4'd0;
            r_row       <= 4'd0;
            r_cur_y     <= 8'd0;
            r_old_y     <= 8'd0;
            r_old_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_col   <= w_col_nx;
            r_row   <= w_row_nx;
            if ((r_state == S_IDLE) && start)
                r_cur_y <= new_y;
            if (r_state == S_FIN) begin
                r_old_y     <= r_cur_y;
                r_old_valid <= 1'b1;
            end
        end
    end

    // Pixel bus holds its last value outside ERASE/DRAW; only plot is forced low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vga_x  <= 8'd0;
            r_vga_y  <= 7'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_plot <= w_pix_active && (w_sum < c_SCREEN_H);
            if (w_pix_active) begin
                r_vga_x  <= c_LANE_X + {4'd0, r_col};
                r_vga_y  <= w_sum[6:0];
                r_colour <= (r_state == S_ERASE) ? BG_COL : NOTE_COL;
            end
            r_done <= (r_state == S_FIN);
            r_busy <= (w_next != S_IDLE) || (r_state == S_FIN);
        end
    end

    assign vga_x  = r_vga_x;
    assign vga_y  = r_vga_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_note_sprite_drawer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_note_sprite_drawer                                        |
// | Description : Self-checking bench for note_sprite_drawer.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_note_sprite_drawer;

    localparam int         c_LANE_X   = 20;
    localparam int         c_SPR_W    = 4;
    localparam int         c_SPR_H    = 4;
    localparam int         c_SCREEN_H = 120;
    localparam int         c_N        = c_SPR_W * c_SPR_H;
    localparam logic [2:0] c_NOTE     = 3'b110;
    localparam logic [2:0] c_BG       = 3'b000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] new_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    bit         m_old_valid;
    logic [7:0] m_old_y;

    typedef struct {
        logic [7:0] y;
        int         plots;
        int         done_c;
        int         inject;
    } vec_t;

    vec_t vecs[7];

    note_sprite_drawer #(
        .LANE_X  (c_LANE_X),
        .SPR_W   (c_SPR_W),
        .SPR_H   (c_SPR_H),
        .SCREEN_H(c_SCREEN_H),
        .NOTE_COL(c_NOTE),
        .BG_COL  (c_BG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .new_y (new_y),
        .vga_x (vga_x),
        .vga_y (vga_y),
        .colour(colour),
        .plot  (plot),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // One frame pass: the model derives every pixel from row-major scan arithmetic.
    // inject: 0 none, -1 random cycle, else cycle index for a stray start pulse.
    task automatic run_pass(input logic [7:0] y, input int tbl_plots, input int tbl_done,
                            input int inject);
        bit skip;
        bit erase;
        int npix;
        int done_c;
        int plots;
        int done_seen;
        int inj;
        skip = 1'b0;
`ifdef SKIP_UNCHANGED_EN
        skip = m_old_valid && (y == m_old_y);
`endif
        erase     = m_old_valid && !skip;
        npix      = skip ? 0 : (erase ? 2 * c_N : c_N);
        done_c    = npix + 2;
        plots     = 0;
        done_seen = -1;
        inj       = (inject < 0) ? 1 + int'($urandom % (done_c - 1)) : inject;

        @(posedge clk); #1;
        start = 1'b1;
        new_y = y;
        @(posedge clk); #1;
        start = 1'b0;
        new_y = 8'($urandom);
        for (int c = 1; c <= done_c + 1; c++) begin
            if (c == inj) begin
                start = 1'b1;
                new_y = y + 8'd37;
            end else begin
                start = 1'b0;
            end
            if (c >= 2 && c <= npix + 1) begin
                int i, k, row, col, sum;
                bit ph_erase;
                i        = c - 2;
                ph_erase = erase && (i < c_N);
                k        = i % c_N;
                col      = k % c_SPR_W;
                row      = k / c_SPR_W;
                sum      = (ph_erase ? int'(m_old_y) : int'(y)) + row;
                check("plot", plot, (sum < c_SCREEN_H) ? 1 : 0);
                check("vga_x", vga_x, c_LANE_X + col);
                check("vga_y", vga_y, sum % 128);
                check("colour", colour, ph_erase ? c_BG : c_NOTE);
            end else begin
                check("plot_idle", plot, 0);
            end
            check("busy", busy, (c <= done_c) ? 1 : 0);
            check("done", done, (c == done_c) ? 1 : 0);
            if (plot === 1'b1) plots++;
            if (done === 1'b1 && done_seen < 0) done_seen = c;
            if (c <= done_c) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        if (tbl_plots >= 0) begin
            check("tbl_plots", plots, tbl_plots);
            check("tbl_done_cycle", done_seen, tbl_done);
        end
        m_old_valid = 1'b1;
        m_old_y     = y;
    endtask

    initial begin
        vecs[0] = '{8'd10,  16, 18, 0};
        vecs[1] = '{8'd12,  32, 34, 0};
        vecs[2] = '{8'd118, 24, 34, 0};
`ifdef SKIP_UNCHANGED_EN
        vecs[3] = '{8'd118,  0,  2, 0};
`else
        vecs[3] = '{8'd118, 16, 34, 0};
`endif
        vecs[4] = '{8'd255,  8, 34, 5};
        vecs[5] = '{8'd40,  16, 34, 0};
`ifdef SKIP_UNCHANGED_EN
        vecs[6] = '{8'd40,   0,  2, 0};
`else
        vecs[6] = '{8'd40,  32, 34, 0};
`endif

        reset       = 1'b1;
        start       = 1'b0;
        new_y       = 8'd0;
        m_old_valid = 1'b0;
        m_old_y     = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_vga_x", vga_x, 0);
        check("rst_vga_y", vga_y, 0);
        check("rst_colour", colour, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        for (int v = 0; v < 7; v++)
            run_pass(vecs[v].y, vecs[v].plots, vecs[v].done_c, vecs[v].inject);

        // Reset lands on the fifth draw pixel of an erase+draw pass.
        @(posedge clk); #1;
        start = 1'b1;
        new_y = 8'd50;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        check("t5_plot_before", plot, 1);
        check("t5_y_before", vga_y, 51);
        check("t5_colour_before", colour, c_NOTE);
        reset = 1'b1;
        #1;
        check("t5_plot_reset", plot, 0);
        check("t5_busy_reset", busy, 0);
        @(posedge clk); #1;
        reset       = 1'b0;
        m_old_valid = 1'b0;
        m_old_y     = 8'd0;
        run_pass(8'd30, 16, 18, 0);

        for (int r = 0; r < 30; r++) begin
            logic [7:0] ry;
            ry = ($urandom_range(0, 3) == 0) ? m_old_y : 8'($urandom_range(0, 255));
            run_pass(ry, -1, -1, ($urandom_range(0, 1) == 1) ? -1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
